// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with single-cycle ALU, destination select,
// and an iterative multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV stall the upstream pipeline while the unit iterates.
// Optional build macro MD_FAST_MULT_EN: MULT/MULTU use a single-cycle
// multiplier and finish at the issue edge; DIV stays iterative.

module ex_muldiv_stage #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        EX_Valid,
  input  logic [3:0]  EX_ALUOp,
  input  logic [31:0] EX_RS,
  input  logic [31:0] EX_RT,
  input  logic [31:0] EX_Imm,
  input  logic        EX_ALUSrc,
  input  logic        EX_RegDst,
  input  logic [4:0]  EX_RD,
  input  logic [4:0]  EX_RT_Addr,
  output logic [31:0] EX_ALUResult,
  output logic        EX_Zero,
  output logic [4:0]  EX_WriteReg,
  output logic        EX_Stall,
  output logic [31:0] EX_HI,
  output logic [31:0] EX_LO
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

  // The counter is 5 bits; the last BUSY step happens when it reaches zero.
  localparam logic [4:0] LAST_COUNT = 5'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } md_state_e;

  md_state_e   state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;

  logic [31:0] b_operand;
  logic [31:0] alu_result;
  logic        is_md_op;
  logic        md_start;
  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] step_next;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

`ifdef MD_FAST_MULT_EN
  logic [63:0] fast_a;
  logic [63:0] fast_b;
  logic [63:0] fast_prod;

  // Sign-extend for MULT so the low 64 bits of the product are correct for both flavours.
  always_comb begin
    fast_a    = {{32{(EX_ALUOp == OP_MULT) & EX_RS[31]}}, EX_RS};
    fast_b    = {{32{(EX_ALUOp == OP_MULT) & b_operand[31]}}, b_operand};
    fast_prod = fast_a * fast_b;
  end
`endif

  assign b_operand = EX_ALUSrc ? EX_Imm : EX_RT;
  assign is_md_op  = (EX_ALUOp == OP_MULT) || (EX_ALUOp == OP_MULTU) || (EX_ALUOp == OP_DIV);
  assign md_start  = EX_Valid && is_md_op;
  assign signed_op = (EX_ALUOp == OP_MULT) || (EX_ALUOp == OP_DIV);
  assign mag_a     = (signed_op && EX_RS[31]) ? (32'd0 - EX_RS) : EX_RS;
  assign mag_b     = (signed_op && b_operand[31]) ? (32'd0 - b_operand) : b_operand;

  // Single-cycle ALU; MD ops report zero because they never write the register file.
  always_comb begin
    alu_result = 32'd0;
    case (EX_ALUOp)
      OP_ADD:  alu_result = EX_RS + b_operand;
      OP_SUB:  alu_result = EX_RS - b_operand;
      OP_AND:  alu_result = EX_RS & b_operand;
      OP_OR:   alu_result = EX_RS | b_operand;
      OP_XOR:  alu_result = EX_RS ^ b_operand;
      OP_NOR:  alu_result = ~(EX_RS | b_operand);
      OP_SLT:  alu_result = {31'd0, $signed(EX_RS) < $signed(b_operand)};
      OP_SLTU: alu_result = {31'd0, EX_RS < b_operand};
      OP_SLL:  alu_result = EX_RT << b_operand[4:0];
      OP_SRL:  alu_result = EX_RT >> b_operand[4:0];
      OP_SRA:  alu_result = $signed(EX_RT) >>> b_operand[4:0];
      OP_MFHI: alu_result = hi_q;
      OP_MFLO: alu_result = lo_q;
      default: alu_result = 32'd0;
    endcase
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    mul_sum   = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, opnd_q}) : {1'b0, acc_q[63:32]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    step_next = {mul_sum, acc_q[31:1]};
    if (is_div_q) begin
      if (!div_diff[32]) begin
        step_next = {div_diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        step_next = {div_shift[31:0], acc_q[30:0], 1'b0};
      end
    end
  end

  // Sign fix-up applied to the final step before it lands in HI/LO.
  always_comb begin
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    prod   = neg_res_q ? (64'd0 - step_next) : step_next;
    quot   = neg_res_q ? (32'd0 - step_next[31:0]) : step_next[31:0];
    rem    = neg_rem_q ? (32'd0 - step_next[63:32]) : step_next[63:32];
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (is_div_q) begin
      fix_hi = rem;
      fix_lo = div_zero_q ? 32'hFFFF_FFFF : quot;
    end
  end

  // Multiply/divide sequencer: latch magnitudes at issue, iterate in BUSY, retire through DONE.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d    = BUSY;
          count_d    = LAST_COUNT;
          is_div_d   = (EX_ALUOp == OP_DIV);
          neg_res_d  = signed_op && (EX_RS[31] ^ b_operand[31]);
          neg_rem_d  = (EX_ALUOp == OP_DIV) && EX_RS[31];
          div_zero_d = (EX_ALUOp == OP_DIV) && (b_operand == 32'd0);
          acc_d      = (EX_ALUOp == OP_DIV) ? {32'd0, mag_a} : {32'd0, mag_b};
          opnd_d     = (EX_ALUOp == OP_DIV) ? mag_b : mag_a;
`ifdef MD_FAST_MULT_EN
          if (EX_ALUOp != OP_DIV) begin
            state_d = DONE;
            count_d = 5'd0;
            hi_d    = fast_prod[63:32];
            lo_d    = fast_prod[31:0];
          end
`endif
        end
      end
      BUSY: begin
        acc_d   = step_next;
        count_d = count_q - 5'd1;
        if (count_q == 5'd0) begin
          count_d = 5'd0;
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and HI/LO registers; reset discards any partial result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      acc_q      <= 64'd0;
      opnd_q     <= 32'd0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign EX_ALUResult = alu_result;
  assign EX_Zero      = (alu_result == 32'd0);
  assign EX_WriteReg  = EX_RegDst ? EX_RD : EX_RT_Addr;
  assign EX_Stall     = !reset && (((state_q == IDLE) && md_start) || (state_q == BUSY));
  assign EX_HI        = hi_q;
  assign EX_LO        = lo_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Testbench for ex_muldiv_stage: table-driven ALU vectors, hand-written
// multiply/divide sequences, reset during BUSY, and randomized traffic
// checked against an arithmetic reference model.

module tb_ex_muldiv_stage;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_SLTU  = 4'd7;
  localparam logic [3:0] OP_SLL   = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_MFHI  = 4'd14;
  localparam logic [3:0] OP_MFLO  = 4'd15;

`ifdef MD_FAST_MULT_EN
  localparam int MULT_STALL = 1;
`else
  localparam int MULT_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  logic        clock = 1'b0;
  logic        reset;
  logic        EX_Valid;
  logic [3:0]  EX_ALUOp;
  logic [31:0] EX_RS;
  logic [31:0] EX_RT;
  logic [31:0] EX_Imm;
  logic        EX_ALUSrc;
  logic        EX_RegDst;
  logic [4:0]  EX_RD;
  logic [4:0]  EX_RT_Addr;
  logic [31:0] EX_ALUResult;
  logic        EX_Zero;
  logic [4:0]  EX_WriteReg;
  logic        EX_Stall;
  logic [31:0] EX_HI;
  logic [31:0] EX_LO;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        aluSrc;
    logic        regDst;
    logic [4:0]  rd;
    logic [4:0]  rtAddr;
    logic [31:0] expResult;
    logic [4:0]  expWriteReg;
  } vec_t;

  vec_t vecs[14];

  ex_muldiv_stage dut (
    .clock       (clock),
    .reset       (reset),
    .EX_Valid    (EX_Valid),
    .EX_ALUOp    (EX_ALUOp),
    .EX_RS       (EX_RS),
    .EX_RT       (EX_RT),
    .EX_Imm      (EX_Imm),
    .EX_ALUSrc   (EX_ALUSrc),
    .EX_RegDst   (EX_RegDst),
    .EX_RD       (EX_RD),
    .EX_RT_Addr  (EX_RT_Addr),
    .EX_ALUResult(EX_ALUResult),
    .EX_Zero     (EX_Zero),
    .EX_WriteReg (EX_WriteReg),
    .EX_Stall    (EX_Stall),
    .EX_HI       (EX_HI),
    .EX_LO       (EX_LO)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] imm, input logic aluSrc,
                               input logic regDst, input logic [4:0] rd, input logic [4:0] rtAddr);
    EX_Valid   = valid;
    EX_ALUOp   = op;
    EX_RS      = rs;
    EX_RT      = rt;
    EX_Imm     = imm;
    EX_ALUSrc  = aluSrc;
    EX_RegDst  = regDst;
    EX_RD      = rd;
    EX_RT_Addr = rtAddr;
  endtask

  // Reference ALU written as plain arithmetic on integers.
  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                         input logic [31:0] imm, input logic aluSrc);
    logic [31:0] b;
    longint      sa;
    longint      sb;
    longint      srt;
    longint      pow2;
    longint      tmp;
    int          amt;
    b    = aluSrc ? imm : rt;
    sa   = longint'($signed(rs));
    sb   = longint'($signed(b));
    srt  = longint'($signed(rt));
    amt  = int'(b % 32);
    pow2 = longint'(1) << amt;
    case (op)
      OP_ADD:  tmp = longint'(rs) + longint'(b);
      OP_SUB:  tmp = longint'(rs) - longint'(b);
      OP_AND:  tmp = longint'(rs & b);
      OP_OR:   tmp = longint'(rs | b);
      OP_XOR:  tmp = longint'(rs ^ b);
      OP_NOR:  tmp = longint'(~(rs | b));
      OP_SLT:  tmp = (sa < sb) ? 1 : 0;
      OP_SLTU: tmp = (longint'(rs) < longint'(b)) ? 1 : 0;
      OP_SLL:  tmp = longint'(rt) * pow2;
      OP_SRL:  tmp = longint'(rt) / pow2;
      OP_SRA:  tmp = (srt >= 0) ? (srt / pow2) : -((-srt + pow2 - 1) / pow2);
      OP_MFHI: tmp = longint'(modelHi);
      OP_MFLO: tmp = longint'(modelLo);
      default: tmp = 0;
    endcase
    return 32'(tmp);
  endfunction

  // Reference multiply/divide from integer arithmetic.
  task automatic refMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    if (op == OP_MULT) begin
      p  = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == OP_MULTU) begin
      p  = 64'(longint'(a) * longint'(b));
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      hi = 32'(sa % sb);
      lo = 32'(sa / sb);
    end
  endtask

  // Issue one MD op, count stall cycles, then read HI/LO back through MFLO/MFHI.
  task automatic runMd(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int stallCycles;
    bit done;
    int expStall;
    expStall    = (op == OP_DIV) ? DIV_STALL : MULT_STALL;
    stallCycles = 0;
    done        = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus(1'b1, op, a, b, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clock);
      if (EX_Stall) begin
        stallCycles++;
        if (cyc == 0) checkOutput({tag, "_md_result_zero"}, EX_ALUResult, 32'd0);
        @(posedge clock);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    checkOutput({tag, "_stall_cycles"}, 32'(stallCycles), 32'(expStall));
    checkOutput({tag, "_hi"}, EX_HI, expHi);
    checkOutput({tag, "_lo"}, EX_LO, expLo);
    modelHi = expHi;
    modelLo = expLo;
    @(posedge clock);
    #1;
    applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clock);
    checkOutput({tag, "_mflo"}, EX_ALUResult, expLo);
    EX_ALUOp = OP_MFHI;
    #1;
    checkOutput({tag, "_mfhi"}, EX_ALUResult, expHi);
    EX_Valid = 1'b0;
  endtask

  initial begin
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic [31:0] expRes;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    //              op        rs            rt            imm           src   dst   rd     rtAddr  result        wreg
    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b0, 5'd9,  5'd4, 32'h80000000, 5'd4};
    vecs[1]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b1, 5'd9,  5'd4, 32'h00000001, 5'd9};
    vecs[2]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b0, 5'd9,  5'd4, 32'h00000000, 5'd4};
    vecs[3]  = '{OP_SRA,  32'h0,        32'h80000000, 32'h4,        1'b1, 1'b1, 5'd9,  5'd4, 32'hF8000000, 5'd9};
    vecs[4]  = '{OP_SUB,  32'h5,        32'h5,        32'h0,        1'b0, 1'b0, 5'd1,  5'd2, 32'h00000000, 5'd2};
    vecs[5]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1'b0, 1'b1, 5'd31, 5'd0, 32'h00F000F0, 5'd31};
    vecs[6]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h0,        1'b0, 1'b0, 5'd3,  5'd7, 32'h12345678, 5'd7};
    vecs[7]  = '{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        1'b0, 1'b0, 5'd3,  5'd8, 32'hF0F00F0F, 5'd8};
    vecs[8]  = '{OP_NOR,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 5'd3,  5'd8, 32'hFFFFFFFF, 5'd8};
    vecs[9]  = '{OP_SLL,  32'h0,        32'h00000003, 32'd31,       1'b1, 1'b0, 5'd3,  5'd8, 32'h80000000, 5'd8};
    vecs[10] = '{OP_SRL,  32'h0,        32'h80000000, 32'h4,        1'b1, 1'b0, 5'd3,  5'd8, 32'h08000000, 5'd8};
    vecs[11] = '{OP_MFHI, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 5'd3,  5'd8, 32'h00000000, 5'd8};
    vecs[12] = '{OP_ADD,  32'h00000010, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 5'd3,  5'd8, 32'h0000000F, 5'd8};
    vecs[13] = '{OP_SLL,  32'h0,        32'h00000001, 32'h00000024, 1'b1, 1'b0, 5'd3,  5'd8, 32'h00000010, 5'd8};

    reset = 1'b1;
    applyStimulus(1'b1, OP_MULT, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    #12;
    checkOutput("reset_stall", 32'(EX_Stall), 32'd0);
    checkOutput("reset_hi", EX_HI, 32'd0);
    checkOutput("reset_lo", EX_LO, 32'd0);
    applyStimulus(1'b0, OP_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    #5;
    reset = 1'b0;

    $display("[TB] table-driven ALU vectors");
    for (int i = 0; i < 14; i++) begin
      @(posedge clock);
      #1;
      applyStimulus(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].aluSrc,
                    vecs[i].regDst, vecs[i].rd, vecs[i].rtAddr);
      @(negedge clock);
      checkOutput($sformatf("vec%0d_result", i), EX_ALUResult, vecs[i].expResult);
      checkOutput($sformatf("vec%0d_zero", i), 32'(EX_Zero), 32'(vecs[i].expResult == 32'd0));
      checkOutput($sformatf("vec%0d_wreg", i), 32'(EX_WriteReg), 32'(vecs[i].expWriteReg));
      checkOutput($sformatf("vec%0d_stall", i), 32'(EX_Stall), 32'd0);
    end

    $display("[TB] MD op with EX_Valid low must not start");
    @(posedge clock);
    #1;
    applyStimulus(1'b0, OP_DIV, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(negedge clock);
    checkOutput("novalid_stall", 32'(EX_Stall), 32'd0);
    @(negedge clock);
    checkOutput("novalid_stall_next", 32'(EX_Stall), 32'd0);
    checkOutput("novalid_lo", EX_LO, 32'd0);

    $display("[TB] hand-written multiply/divide sequences");
    runMd("multu",     OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
    runMd("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    runMd("div_zero",  OP_DIV,   32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF);
    runMd("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runMd("mult",      OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);

    $display("[TB] reset during BUSY");
    @(posedge clock);
    #1;
    applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    @(posedge clock);
    repeat (21) @(posedge clock);
    #2;
    checkOutput("busy_stall_before_reset", 32'(EX_Stall), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_stall", 32'(EX_Stall), 32'd0);
    checkOutput("reset_mid_hi", EX_HI, 32'd0);
    checkOutput("reset_mid_lo", EX_LO, 32'd0);
    modelHi = 32'd0;
    modelLo = 32'd0;
    applyStimulus(1'b1, OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    #3;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("after_reset_mfhi", EX_ALUResult, 32'd0);
    checkOutput("after_reset_stall", 32'(EX_Stall), 32'd0);
    EX_Valid = 1'b0;
    runMd("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("[TB] randomized ALU vectors");
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      op = 4'($urandom_range(0, 12));
      if (op == 4'd11) op = OP_MFHI;
      if (op == 4'd12) op = OP_MFLO;
      applyStimulus(1'b1, op, $urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom()), 5'($urandom()));
      expRes = refAlu(EX_ALUOp, EX_RS, EX_RT, EX_Imm, EX_ALUSrc);
      @(negedge clock);
      checkOutput($sformatf("rnd%0d_op%0d_result", i, op), EX_ALUResult, expRes);
      checkOutput($sformatf("rnd%0d_zero", i), 32'(EX_Zero), 32'(expRes == 32'd0));
      checkOutput($sformatf("rnd%0d_wreg", i), 32'(EX_WriteReg), 32'(EX_RegDst ? EX_RD : EX_RT_Addr));
    end

    $display("[TB] randomized multiply/divide");
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(11, 13));
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) b = 32'd0 - b;
      refMd(op, a, b, expHi, expLo);
      runMd($sformatf("rndmd%0d_op%0d", i, op), op, a, b, expHi, expLo);
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
- Execute stage that consumes the ID/EX pipeline register outputs.
- Computes single-cycle ALU results and the destination register address, and drives the EX/MEM register.
- Contains an iterative multiply/divide unit with HI/LO registers.
- Asserts a stall to freeze IF/ID/ID_EX while a MULT/DIV is in progress.

Parameters:
- MD_CYCLES, 32, iterations per multiply/divide; fixed at 32 for 32-bit operands; counter width is 5 bits.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- EX_Valid  input  1  a valid instruction occupies EX this cycle
- EX_ALUOp  input  4  operation select (encoding below)
- EX_RS  input  32  operand A
- EX_RT  input  32  register operand B
- EX_Imm  input  32  sign-extended immediate
- EX_ALUSrc  input  1  1: B = EX_Imm; 0: B = EX_RT
- EX_RegDst  input  1  1: write register = EX_RD; 0: write register = EX_RT_Addr
- EX_RD  input  5  rd field
- EX_RT_Addr  input  5  rt field
- EX_ALUResult  output  32  result to EX/MEM
- EX_Zero  output  1  EX_ALUResult == 0
- EX_WriteReg  output  5  selected destination register
- EX_Stall  output  1  hold upstream stages and insert a bubble into EX/MEM
- EX_HI  output  32  HI register
- EX_LO  output  32  LO register

Behaviour:
- ALUOp encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA: value = EX_RT, amount = B[4:0]
  - 11 MULT, 12 MULTU, 13 DIV (signed), 14 MFHI, 15 MFLO
- ALU ops 0-10 and 14-15 are combinational, with zero added latency. ADD/SUB wrap modulo 2^32; no overflow trap.
- For ops 11-13, EX_ALUResult = 0. The instruction does not write the register file; downstream gates RegWrite with EX_Stall.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if EX_Valid and op is 11-13, EX_Stall = 1 combinationally. At the edge: latch operands (magnitudes plus sign flags for MULT/DIV), count = 31, go to BUSY.
  - BUSY: EX_Stall = 1. Each edge performs one shift-add (multiply) or one restoring-subtract (divide) step and decrements count. At the edge where count == 0, apply the sign fix-up, write HI/LO, and go to DONE.
  - DONE: EX_Stall = 0. The instruction in EX is treated as complete and is not re-issued. Go to IDLE at the next edge.
- Latency: the issue cycle plus 32 BUSY cycles gives 33 stall cycles. HI/LO are readable by an MFHI/MFLO in the cycle after DONE.
- MULT/MULTU: HI:LO = 64-bit product. DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
- Boundary cases:
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend.
  - 0x80000000 / -1: LO = 0x80000000, HI = 0.
- A new MD op appearing in DONE is impossible because EX has not advanced yet. It is ignored; the FSM always returns to IDLE first.
- Reset, asynchronous at any time including mid-BUSY:
  - state = IDLE, count = 0, HI = LO = 0, internal accumulators = 0.
  - EX_Stall = 0 while reset is high. Any partial result is discarded.
- EX_Valid = 0 in IDLE: no MD start and EX_Stall = 0. Combinational outputs still follow their inputs.

Optional Feature:
- Macro: MD_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle 32x32 multiplier. From IDLE they go straight to DONE, writing HI/LO at the issue edge, so the stall is 1 cycle. DIV is unchanged at 33 stall cycles.
- Undefined: all MD ops are iterative, as specified above.

Test Plan:
- ADD: RS = 0x7FFFFFFF, RT = 1, ALUSrc = 0 -> ALUResult 0x80000000, Zero = 0. SLT with RS = 0xFFFFFFFF, RT = 1 -> 1. SLTU with the same operands -> 0.
- MULT: RS = -3, RT = 5 -> Stall high for exactly 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; the following MFLO returns 0xFFFFFFF1.
- MULTU: RS = 0xFFFFFFFF, RT = 2 -> HI = 0x00000001, LO = 0xFFFFFFFE. With MD_FAST_MULT_EN defined -> Stall high for 1 cycle only.
- DIV: RS = -7, RT = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 5 / 0 -> LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- Reset pulse at BUSY count 10 during DIV 100 / 7 -> Stall drops immediately; HI = LO = 0; a subsequent MFHI returns 0; the next DIV 100 / 7 gives LO = 14, HI = 2.
- RegDst = 1, RD = 9, RT_Addr = 4 -> WriteReg = 9. RegDst = 0 -> WriteReg = 4. SRA with RT = 0x80000000, Imm = 4, ALUSrc = 1 -> 0xF8000000.
